// File: rtl/i2s_rx_axis.sv
// I2S receiver: oversampled sck/ws/sd, stereo frames out on an AXI-stream master.
// Define I2S_RX_OVF_CNT_EN to add the saturating dropped-frame counter ovf_cnt.
module i2s_rx_axis #(
    parameter int WIDTH = 24,
    parameter int SLOT  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i2s_sck,
    input  logic               i2s_ws,
    input  logic               i2s_sd,
    output logic [2*WIDTH-1:0] m_data,
    output logic               m_vld,
    input  logic               m_rdy,
    output logic               ovf,
    input  logic               ovf_clr
`ifdef I2S_RX_OVF_CNT_EN
    ,
    output logic [15:0]        ovf_cnt
`endif
);

    typedef enum logic [1:0] {
        SYNC,
        LEFT,
        RIGHT
    } state_t;

    logic [2:0]         sck_sync_q;
    logic [1:0]         ws_sync_q;
    logic [1:0]         sd_sync_q;
    logic               ev_q;
    logic               ev_ws_q;
    logic               ev_sd_q;
    logic               ws_d_q;
    logic [5:0]         bit_cnt_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH-1:0]   left_hold_q;
    logic [WIDTH-1:0]   word_d;
    state_t             state_q;
    logic [2*WIDTH-1:0] data_q;
    logic               vld_q;
    logic               ovf_q;
    logic               bnd;
    logic               done;
    logic               xfer;
    logic               load;
    logic               drop;
    logic               unused_slot;

    // Slot length only matters to the serial source; capture adapts to any length.
    assign unused_slot = (SLOT > 0);

    always_comb begin
        word_d = shreg_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(bit_cnt_q) == WIDTH - 1 - i) begin
                word_d[i] = ev_sd_q;
            end
        end
        bnd  = ev_q && (ev_ws_q != ws_d_q);
        done = bnd && (state_q == RIGHT);
        xfer = vld_q && m_rdy;
        load = done && (!vld_q || m_rdy);
        drop = done && vld_q && !m_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            ev_q        <= 1'b0;
            ev_ws_q     <= 1'b0;
            ev_sd_q     <= 1'b0;
            ws_d_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            state_q     <= SYNC;
            data_q      <= '0;
            vld_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], i2s_sck};
            ws_sync_q  <= {ws_sync_q[0], i2s_ws};
            sd_sync_q  <= {sd_sync_q[0], i2s_sd};
            ev_q       <= sck_sync_q[1] & ~sck_sync_q[2];
            ev_ws_q    <= ws_sync_q[1];
            ev_sd_q    <= sd_sync_q[1];
            if (ev_q) begin
                ws_d_q <= ev_ws_q;
                if (bnd) begin
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                end else begin
                    shreg_q <= word_d;
                    if (bit_cnt_q != 6'd63) begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                    end
                end
            end
            if (bnd) begin
                case (state_q)
                    SYNC: begin
                        if (!ev_ws_q) begin
                            state_q <= LEFT;
                        end
                    end
                    LEFT: begin
                        left_hold_q <= word_d;
                        state_q     <= RIGHT;
                    end
                    RIGHT: begin
                        state_q <= LEFT;
                    end
                    default: begin
                        state_q <= SYNC;
                    end
                endcase
            end
            if (load) begin
                data_q <= {left_hold_q, word_d};
                vld_q  <= 1'b1;
            end else if (xfer) begin
                vld_q <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                cnt_q <= 16'd1;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            cnt_q <= '0;
        end
    end

    assign ovf_cnt = cnt_q;
`endif

    assign m_data = data_q;
    assign m_vld  = vld_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_i2s_rx_axis.sv
// Self-checking bench for i2s_rx_axis: vector table, corner sequences, random frames.
// Expected frames come from a slot-level model and a scoreboard queue.
module tb_i2s_rx_axis;

    localparam int W = 24;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          n;
        logic [47:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        rdy_cmd;
    logic        rnd_en = 1'b0;
    logic        rnd_rdy = 1'b1;
    logic        m_rdy;
    logic        ovf_clr;
    logic [47:0] m_data;
    logic        m_vld;
    logic        ovf;
`ifdef I2S_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          stall = 0;
    int          lat;
    logic [47:0] mon_e;
    logic [47:0] exp_q[$];
    vec_t        tbl[7];

    assign m_rdy = rnd_en ? rnd_rdy : rdy_cmd;

    i2s_rx_axis #(
        .WIDTH(24),
        .SLOT (32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i2s_sck(sck),
        .i2s_ws (ws),
        .i2s_sd (sd),
        .m_data (m_data),
        .m_vld  (m_vld),
        .m_rdy  (m_rdy),
        .ovf    (ovf),
        .ovf_clr(ovf_clr)
`ifdef I2S_RX_OVF_CNT_EN
        ,
        .ovf_cnt(ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // One sck period: 4 clk low with ws/sd set up, then 4 clk high.
    task automatic send_bit(input logic w, input logic d);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_slot(input logic ch, input logic [23:0] v,
                             input int n, input int k0, input int k1,
                             input bit junk);
        for (int k = k0; k < k1; k++) begin
            logic d;
            if (k < W) d = v[W-1-k];
            else d = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            send_bit((k == n - 1) ? ~ch : ch, d);
        end
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                              input int n, input bit junk);
        send_slot(1'b0, l, n, 0, n, junk);
        send_slot(1'b1, r, n, 0, n, junk);
    endtask

    task automatic send_frame_open(input logic [23:0] l,
                                   input logic [23:0] r, input int n);
        send_slot(1'b0, l, n, 0, n, 1'b0);
        send_slot(1'b1, r, n, 0, n - 1, 1'b0);
    endtask

    // A slot of n bits carries only the top n sample bits.
    function automatic logic [47:0] model(input logic [23:0] l,
                                          input logic [23:0] r, input int n);
        logic [23:0] m;
        if (n >= W) m = '1;
        else m = ~((24'd1 << (W - n)) - 24'd1);
        return {l & m, r & m};
    endfunction

    always @(negedge clk) begin
        if (rnd_en) begin
            stall = (m_vld && !m_rdy) ? stall + 1 : 0;
            rnd_rdy = ($urandom_range(0, 1) == 1) || (stall >= 3);
        end else begin
            stall = 0;
            rnd_rdy = 1'b1;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && m_vld && m_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected got=%h want=none", m_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer", {16'h0, m_data}, {16'h0, mon_e});
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout got=running want=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{24'h123456, 24'hABCDEF, 32, 48'h123456ABCDEF};
        tbl[1] = '{24'h123400, 24'h800100, 16, 48'h123400800100};
        tbl[2] = '{24'hFFFFFF, 24'h000000, 24, 48'hFFFFFF000000};
        tbl[3] = '{24'h000001, 24'h800000, 25, 48'h000001800000};
        tbl[4] = '{24'hA5A5A5, 24'h5A5A5A, 64, 48'hA5A5A55A5A5A};
        tbl[5] = '{24'h800000, 24'hFFFFFF, 1, 48'h800000800000};
        tbl[6] = '{24'hABCDEF, 24'h123456, 8, 48'hAB0000120000};

        rst = 1'b1;
        sck = 1'b0;
        ws = 1'b1;
        sd = 1'b0;
        rdy_cmd = 1'b1;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vld", m_vld, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ovf", ovf, 0);
`ifdef I2S_RX_OVF_CNT_EN
        chk("rst_cnt", ovf_cnt, 0);
`endif

        // Leave reset partway through a right slot.
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
        chk("mid_start_idle", m_vld, 0);
        send_bit(1'b0, 1'($urandom_range(0, 1)));
        chk("mid_start_idle2", m_vld, 0);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(tbl[i].exp);
            send_frame(tbl[i].l, tbl[i].r, tbl[i].n, 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("tbl_drain", exp_q.size(), 0);
        chk("tbl_ovf", ovf, 0);

        exp_q.push_back(48'h123456ABCDEF);
        send_frame_open(24'h123456, 24'hABCDEF, 32);
        chk("lat_pre_vld", m_vld, 0);
        fork
            send_bit(1'b0, 1'b0);
            begin
                lat = 0;
                repeat (4) @(negedge clk);
                for (int i = 1; i <= 8 && lat == 0; i++) begin
                    @(posedge clk);
                    #1;
                    if (m_vld) lat = i;
                end
                chk("latency", lat, 4);
            end
        join
        repeat (2) @(negedge clk);
        chk("lat_drain", exp_q.size(), 0);

        rdy_cmd = 1'b0;
        exp_q.push_back(48'h111111222222);
        send_frame(24'h111111, 24'h222222, 32, 1'b0);
        send_frame(24'h333333, 24'h444444, 32, 1'b0);
        repeat (2) @(negedge clk);
        chk("bp_vld", m_vld, 1);
        chk("bp_data", m_data, 48'h111111222222);
        chk("bp_ovf", ovf, 1);
`ifdef I2S_RX_OVF_CNT_EN
        chk("bp_cnt", ovf_cnt, 1);
`endif
        rdy_cmd = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_after_vld", m_vld, 0);
        chk("bp_sticky", ovf, 1);
        chk("bp_drain", exp_q.size(), 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("bp_clr", ovf, 0);
`ifdef I2S_RX_OVF_CNT_EN
        chk("bp_cnt_clr", ovf_cnt, 0);
`endif

        // Ready rises in the very cycle the next frame lands.
        rdy_cmd = 1'b0;
        exp_q.push_back(48'h0A0B0C0D0E0F);
        send_frame(24'h0A0B0C, 24'h0D0E0F, 32, 1'b0);
        chk("sim_hold", m_vld, 1);
        exp_q.push_back(48'h5555AAAA5555);
        send_frame_open(24'h5555AA, 24'hAA5555, 32);
        fork
            send_bit(1'b0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rdy_cmd = 1'b1;
            end
        join
        repeat (2) @(negedge clk);
        chk("sim_drain", exp_q.size(), 0);
        chk("sim_ovf", ovf, 0);

        rdy_cmd = 1'b0;
        exp_q.push_back(48'h999999666666);
        send_frame(24'h999999, 24'h666666, 32, 1'b0);
        send_frame(24'h121212, 24'h343434, 32, 1'b0);
        chk("rm_pre_ovf", ovf, 1);
        send_slot(1'b0, 24'h777777, 32, 0, 12, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("rm_vld", m_vld, 0);
        chk("rm_ovf", ovf, 0);
        rdy_cmd = 1'b1;
        send_slot(1'b0, 24'h777777, 32, 12, 32, 1'b0);
        send_slot(1'b1, 24'h888888, 32, 0, 32, 1'b0);
        chk("rm_idle", m_vld, 0);
        exp_q.push_back(48'hC0FFEE00BEEF);
        send_frame(24'hC0FFEE, 24'h00BEEF, 32, 1'b0);
        repeat (2) @(negedge clk);
        chk("rm_drain", exp_q.size(), 0);

        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [23:0] l;
            logic [23:0] r;
            int n;
            l = 24'($urandom);
            r = 24'($urandom);
            n = $urandom_range(1, 64);
            exp_q.push_back(model(l, r, n));
            send_frame(l, r, n, 1'b1);
        end
        rnd_en = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("rnd_drain", exp_q.size(), 0);
        chk("rnd_ovf", ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
